// File: rtl/alu_pkg.sv
// alu_pkg: function codes shared by the ALU output mux and the Hi/Lo divider, plus divider FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

  // Function codes presented on the Signal bus
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_DIVU = 6'b011011;
  localparam logic [5:0] FN_MFHI = 6'b010000;
  localparam logic [5:0] FN_MFLO = 6'b010010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } divu_state_t;

endpackage

// File: rtl/divu_hilo.sv
// divu_hilo: WIDTH-step restoring unsigned divider; quotient -> LoOut, remainder -> HiOut.
// Latency: start edge E0, HiOut/LoOut and done at E0+WIDTH, next start accepted at E0+WIDTH+1.
// Backpressure: none; DIVU codes arriving while busy are dropped, the controller stalls on busy.
module divu_hilo
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [5:0]       Signal,
  output logic [WIDTH-1:0] HiOut,
  output logic [WIDTH-1:0] LoOut,
  output logic             busy,
  output logic             done
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  divu_state_t      state_q, state_d;
  logic [WIDTH:0]   rem_q, rem_d;      // extra MSB carries the trial-subtract sign
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [2*WIDTH:0] shifted;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_quo;
  logic             start;

  assign start = (Signal == FN_DIVU);

  // One restoring step: shift {rem, quo} left, trial-subtract, keep or restore
  always_comb begin
    shifted  = {rem_q, quo_q} << 1;
    rem_sh   = shifted[2*WIDTH:WIDTH];
    trial    = rem_sh - {1'b0, dvs_q};
    step_rem = trial[WIDTH] ? rem_sh : trial;
    step_quo = shifted[WIDTH-1:0] | {{(WIDTH-1){1'b0}}, ~trial[WIDTH]};
  end

  // Next-state logic; DONE's exit edge doubles as the first IDLE sampling edge,
  // which is what gives the one-divide-per-(WIDTH+1)-cycles back-to-back rate
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        if (start) begin
          state_d = CALC;
          quo_d   = dataA;
          dvs_d   = dataB;
          rem_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          hi_d    = step_rem[WIDTH-1:0];
          lo_d    = step_quo;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset clears results so an aborted divide reads 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign HiOut = hi_q;
  assign LoOut = lo_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule
